reg_file_g: RTL and testbench
=============================

REG_FILE_G -- requirements
Module: reg_file_g

Interface
REQ-001 Parameter WIDTH, default 8: data bits per register, SHALL be at least 1.
REQ-002 Parameter DEPTH, default 8: number of registers, SHALL be a power of two, at least 2.
REQ-003 Parameter ZERO_REG, default 1: if 1, register 0 reads as all-zero and ignores writes.
REQ-004 Parameter BYPASS, default 1: if 1, a same-cycle write is forwarded to a matching read port.
REQ-005 Ports SHALL be:
- CLK  in  1  clock, rising-edge active.
- RST  in  1  reset, asynchronous, active-high.
- WE  in  1  write enable.
- WADDR  in  log2(DEPTH)  write address.
- WDATA  in  WIDTH  write data.
- RADDR_A  in  log2(DEPTH)  read address, port A.
- RDATA_A  out  WIDTH  read data, port A.
- RDATA_A_N  out  WIDTH  bitwise complement of RDATA_A.
- RADDR_B  in  log2(DEPTH)  read address, port B.
- RDATA_B  out  WIDTH  read data, port B.
- WRITTEN  out  DEPTH  per-register flag: written since reset.

Function
REQ-006 On a rising CLK edge with WE=1 and RST=0, register[WADDR] SHALL take WDATA, and WRITTEN[WADDR] SHALL set to 1.
REQ-007 With WE=0, every register and every WRITTEN bit SHALL hold its value.
REQ-008 Reads SHALL be combinational (zero latency): RDATA_x = register[RADDR_x], with no clock involved.
REQ-009 RDATA_A_N SHALL equal ~RDATA_A at all times, including during reset.
REQ-010 If ZERO_REG=1:
- a write to address 0 SHALL be discarded;
- WRITTEN[0] SHALL stay 0;
- a read of address 0 SHALL return 0.
REQ-011 If BYPASS=1, WE=1 and RADDR_x == WADDR (excluding address 0 when ZERO_REG=1), RDATA_x SHALL equal WDATA in the same cycle.
REQ-012 If BYPASS=0, read data SHALL show the old value until after the write edge.
REQ-013 Ports A and B SHALL be independent; both SHALL be able to read the same address, with or without bypass.
REQ-014 An address is always in range (DEPTH is a power of two), so no out-of-range handling is needed.
REQ-015 On a write, only the addressed register SHALL change.

Reset
REQ-016 Asserting RST SHALL immediately, without waiting for CLK, clear:
- every register to 0;
- WRITTEN to 0.
As a result RDATA_A=RDATA_B=0 and RDATA_A_N is all ones.
REQ-017 While RST=1, writes SHALL be ignored, and bypass SHALL be suppressed (read data 0).
REQ-018 RST asserted during a write cycle SHALL win; the write SHALL be lost.
REQ-019 The first write after RST deasserts SHALL take effect on the next rising CLK edge.

Structure
REQ-020 A shared package reg_file_pkg SHALL hold:
- the default WIDTH and DEPTH constants;
- an address-width function, clog2.
REQ-021 Each storage word SHALL be one instance of the sub-module d_register_en. It has ports CLK, RST, En, D[WIDTH] and Q[WIDTH]: an edge-triggered register with enable and asynchronous clear, generated DEPTH times.
REQ-022 Write decode, bypass muxing and the complement output SHALL be in reg_file_g itself, not in d_register_en.

Verification
REQ-023 Reset: assert RST mid-simulation with no clock edge. RDATA_A/B must be 0x00, RDATA_A_N 0xFF and WRITTEN 0x00, all in the same timestep.
REQ-024 Write/read: write 0xA5 to address 3 and 0x3C to address 5. Then RADDR_A=3, RADDR_B=5 must give RDATA_A=0xA5, RDATA_B=0x3C and WRITTEN=0x28.
REQ-025 Zero register: WE=1, WADDR=0, WDATA=0xFF. Then a read of address 0 must give 0x00, and WRITTEN[0] must be 0.
REQ-026 Bypass: WE=1, WADDR=RADDR_A=RADDR_B=6, WDATA=0x77, before the edge. Both ports must show 0x77. With BYPASS=0 both must show the old 0x00 until the edge.
REQ-027 Reset during write: WE=1, WADDR=2, WDATA=0x11, with RST pulsed high across the CLK edge. Register 2 must read 0x00 and WRITTEN must stay 0.
REQ-028 Parameter sweep: WIDTH=1, DEPTH=2 and WIDTH=16, DEPTH=32. Write every address with its own index, then read all addresses back on both ports and check the values.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the reg_file_g register file.
package reg_file_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    // Ceiling log2; returns at least 1 so a 2-entry file still gets a 1-bit address.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/d_register_en.sv
// Edge-triggered storage word with write enable and asynchronous clear.
module d_register_en #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             En,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_q <= '0;
        else if (En)
            r_q <= D;
    end

    assign Q = r_q;

endmodule

// File: rtl/reg_file_g.sv
// One-write, two-read register file with optional hard-wired zero register and write bypass.
module reg_file_g
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      WE,
    input  logic [clog2(DEPTH)-1:0]   WADDR,
    input  logic [WIDTH-1:0]          WDATA,
    input  logic [clog2(DEPTH)-1:0]   RADDR_A,
    output logic [WIDTH-1:0]          RDATA_A,
    output logic [WIDTH-1:0]          RDATA_A_N,
    input  logic [clog2(DEPTH)-1:0]   RADDR_B,
    output logic [WIDTH-1:0]          RDATA_B,
    output logic [DEPTH-1:0]          WRITTEN
);

    localparam int AW = clog2(DEPTH);

    logic             w_zero_waddr;
    logic             w_wr_ok;
    logic             w_byp_ok;
    logic [DEPTH-1:0] w_en;
    logic [WIDTH-1:0] w_q [DEPTH];
    logic [WIDTH-1:0] w_rdata_a;
    logic [WIDTH-1:0] w_rdata_b;
    logic [DEPTH-1:0] r_written;

    assign w_zero_waddr = (ZERO_REG != 0) && (WADDR == '0);
    assign w_wr_ok      = WE && !w_zero_waddr;
    // Bypass is masked by RST so read data stays zero throughout reset.
    assign w_byp_ok     = (BYPASS != 0) && w_wr_ok && !RST;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            assign w_en[gi] = w_wr_ok && (WADDR == AW'(gi));

            d_register_en #(
                .WIDTH (WIDTH)
            ) u_word (
                .CLK (CLK),
                .RST (RST),
                .En  (w_en[gi]),
                .D   (WDATA),
                .Q   (w_q[gi])
            );
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_written <= '0;
        else if (w_wr_ok)
            r_written[WADDR] <= 1'b1;
    end

    always_comb begin
        w_rdata_a = w_q[RADDR_A];
        if ((ZERO_REG != 0) && (RADDR_A == '0))
            w_rdata_a = '0;
        else if (w_byp_ok && (RADDR_A == WADDR))
            w_rdata_a = WDATA;
    end

    always_comb begin
        w_rdata_b = w_q[RADDR_B];
        if ((ZERO_REG != 0) && (RADDR_B == '0))
            w_rdata_b = '0;
        else if (w_byp_ok && (RADDR_B == WADDR))
            w_rdata_b = WDATA;
    end

    assign RDATA_A   = w_rdata_a;
    assign RDATA_A_N = ~w_rdata_a;
    assign RDATA_B   = w_rdata_b;
    assign WRITTEN   = r_written;

endmodule

// File: tb/tb_reg_file_g.sv
// Directed self-checking bench for reg_file_g: defaults, BYPASS=0, and two size corners.
module tb_reg_file_g;

    logic        CLK;
    logic        RST;
    logic        WE;
    logic [2:0]  WADDR;
    logic [7:0]  WDATA;
    logic [2:0]  RADDR_A;
    logic [2:0]  RADDR_B;
    logic [7:0]  RDATA_A, RDATA_A_N, RDATA_B;
    logic [7:0]  WRITTEN;
    logic [7:0]  nb_rdata_a, nb_rdata_a_n, nb_rdata_b;
    logic [7:0]  nb_written;

    logic        s_we;
    logic [0:0]  s_waddr, s_raddr_a, s_raddr_b;
    logic [0:0]  s_wdata, s_rdata_a, s_rdata_a_n, s_rdata_b;
    logic [1:0]  s_written;

    logic        l_we;
    logic [4:0]  l_waddr, l_raddr_a, l_raddr_b;
    logic [15:0] l_wdata, l_rdata_a, l_rdata_a_n, l_rdata_b;
    logic [31:0] l_written;

    int ntests = 0;
    int nfail  = 0;

    reg_file_g dut (
        .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .RADDR_A(RADDR_A), .RDATA_A(RDATA_A), .RDATA_A_N(RDATA_A_N),
        .RADDR_B(RADDR_B), .RDATA_B(RDATA_B), .WRITTEN(WRITTEN)
    );

    reg_file_g #(.BYPASS(0)) dut_nb (
        .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .RADDR_A(RADDR_A), .RDATA_A(nb_rdata_a), .RDATA_A_N(nb_rdata_a_n),
        .RADDR_B(RADDR_B), .RDATA_B(nb_rdata_b), .WRITTEN(nb_written)
    );

    reg_file_g #(.WIDTH(1), .DEPTH(2)) dut_s (
        .CLK(CLK), .RST(RST), .WE(s_we), .WADDR(s_waddr), .WDATA(s_wdata),
        .RADDR_A(s_raddr_a), .RDATA_A(s_rdata_a), .RDATA_A_N(s_rdata_a_n),
        .RADDR_B(s_raddr_b), .RDATA_B(s_rdata_b), .WRITTEN(s_written)
    );

    reg_file_g #(.WIDTH(16), .DEPTH(32)) dut_l (
        .CLK(CLK), .RST(RST), .WE(l_we), .WADDR(l_waddr), .WDATA(l_wdata),
        .RADDR_A(l_raddr_a), .RDATA_A(l_rdata_a), .RDATA_A_N(l_rdata_a_n),
        .RADDR_B(l_raddr_b), .RDATA_B(l_rdata_b), .WRITTEN(l_written)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge CLK);
        WE = 1'b1; WADDR = a; WDATA = d;
        @(posedge CLK);
        #1;
        WE = 1'b0;
    endtask

    initial begin
        RST = 1'b1; WE = 1'b0; WADDR = '0; WDATA = '0; RADDR_A = '0; RADDR_B = '0;
        s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_raddr_a = '0; s_raddr_b = '0;
        l_we = 1'b0; l_waddr = '0; l_wdata = '0; l_raddr_a = '0; l_raddr_b = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // Seed a value so the asynchronous reset has something to clear.
        wr(3'd3, 8'h11);
        RADDR_A = 3'd3; RADDR_B = 3'd3;
        #1;
        chk("pre_rst_a", 32'(RDATA_A), 32'h11);
        chk("pre_rst_written", 32'(WRITTEN), 32'h08);

        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("rst_rdata_a", 32'(RDATA_A), 32'h00);
        chk("rst_rdata_a_n", 32'(RDATA_A_N), 32'hFF);
        chk("rst_rdata_b", 32'(RDATA_B), 32'h00);
        chk("rst_written", 32'(WRITTEN), 32'h00);
        WE = 1'b1; WADDR = 3'd3; WDATA = 8'h5A;
        #1;
        chk("rst_no_bypass_a", 32'(RDATA_A), 32'h00);
        chk("rst_no_bypass_a_n", 32'(RDATA_A_N), 32'hFF);
        @(negedge CLK);
        RST = 1'b0; WE = 1'b0;
        #1;
        chk("rst_write_ignored", 32'(RDATA_A), 32'h00);

        wr(3'd3, 8'hA5);
        wr(3'd5, 8'h3C);
        RADDR_A = 3'd3; RADDR_B = 3'd5;
        #1;
        chk("wr_rdata_a", 32'(RDATA_A), 32'hA5);
        chk("wr_rdata_a_n", 32'(RDATA_A_N), 32'h5A);
        chk("wr_rdata_b", 32'(RDATA_B), 32'h3C);
        chk("wr_written", 32'(WRITTEN), 32'h28);
        chk("nb_wr_rdata_b", 32'(nb_rdata_b), 32'h3C);

        @(negedge CLK);
        WE = 1'b1; WADDR = 3'd0; WDATA = 8'hFF; RADDR_A = 3'd0;
        #1;
        chk("zero_no_bypass", 32'(RDATA_A), 32'h00);
        @(posedge CLK);
        #1;
        WE = 1'b0;
        #1;
        chk("zero_read", 32'(RDATA_A), 32'h00);
        chk("zero_written", 32'(WRITTEN), 32'h28);

        @(negedge CLK);
        WE = 1'b1; WADDR = 3'd6; WDATA = 8'h77; RADDR_A = 3'd6; RADDR_B = 3'd6;
        #1;
        chk("byp_a", 32'(RDATA_A), 32'h77);
        chk("byp_b", 32'(RDATA_B), 32'h77);
        chk("byp_a_n", 32'(RDATA_A_N), 32'h88);
        chk("nobyp_a_old", 32'(nb_rdata_a), 32'h00);
        chk("nobyp_b_old", 32'(nb_rdata_b), 32'h00);
        @(posedge CLK);
        #1;
        WE = 1'b0;
        #1;
        chk("nobyp_a_new", 32'(nb_rdata_a), 32'h77);
        chk("nobyp_b_new", 32'(nb_rdata_b), 32'h77);
        chk("byp_written", 32'(WRITTEN), 32'h68);
        RADDR_A = 3'd3; RADDR_B = 3'd5;
        #1;
        chk("others_keep_a", 32'(RDATA_A), 32'hA5);
        chk("others_keep_b", 32'(RDATA_B), 32'h3C);

        // Reset held across the write edge must win over the write.
        @(negedge CLK);
        WE = 1'b1; WADDR = 3'd2; WDATA = 8'h11; RADDR_A = 3'd2; RADDR_B = 3'd6;
        #3;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("rstwr_during_a", 32'(RDATA_A), 32'h00);
        @(negedge CLK);
        RST = 1'b0; WE = 1'b0;
        #1;
        chk("rstwr_reg2", 32'(RDATA_A), 32'h00);
        chk("rstwr_reg6_cleared", 32'(RDATA_B), 32'h00);
        chk("rstwr_written", 32'(WRITTEN), 32'h00);

        @(negedge CLK);
        WE = 1'b1; WADDR = 3'd4; WDATA = 8'h42; RADDR_A = 3'd4;
        #1;
        chk("first_wr_before", 32'(nb_rdata_a), 32'h00);
        @(posedge CLK);
        #1;
        WE = 1'b0;
        #1;
        chk("first_wr_after", 32'(nb_rdata_a), 32'h42);
        chk("first_wr_written", 32'(nb_written), 32'h10);

        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            s_we = 1'b1; s_waddr = 1'(i); s_wdata = 1'(i);
            @(posedge CLK);
            #1;
            s_we = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            s_raddr_a = 1'(i); s_raddr_b = 1'(i);
            #1;
            chk($sformatf("s_rd_a[%0d]", i), 32'(s_rdata_a), 32'(i));
            chk($sformatf("s_rd_b[%0d]", i), 32'(s_rdata_b), 32'(i));
        end
        chk("s_written", 32'(s_written), 32'h2);

        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            l_we = 1'b1; l_waddr = 5'(i); l_wdata = 16'(i);
            @(posedge CLK);
            #1;
            l_we = 1'b0;
        end
        for (int i = 0; i < 32; i++) begin
            l_raddr_a = 5'(i); l_raddr_b = 5'(31 - i);
            #1;
            chk($sformatf("l_rd_a[%0d]", i), 32'(l_rdata_a), 32'(i));
            chk($sformatf("l_rd_b[%0d]", 31 - i), 32'(l_rdata_b), 32'(31 - i));
        end
        chk("l_written", l_written, 32'hFFFF_FFFE);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
